// File: rtl/doa_scan_ctrl.sv
// Snapshot-hold / steering-sweep sequencer for the 4-channel steered-power datapath; reports argmax angle.
// Optional per-index spectrum output enabled by defining DOA_SPECTRUM_OUT_EN.
module doa_scan_ctrl #(
  parameter int WORD_LENGTH = 16,
  parameter int PWR_WIDTH   = 2*(2*WORD_LENGTH+3)+1,
  parameter int N_ANGLES    = 181,
  parameter int IDX_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [8*WORD_LENGTH-1:0] s_iq,
  output logic [8*WORD_LENGTH-1:0] x_iq,
  output logic                     steer_en,
  output logic [IDX_WIDTH-1:0]     steer_addr,
  input  logic [PWR_WIDTH-1:0]     pwr_in,
  input  logic                     abort,
  output logic                     busy,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [IDX_WIDTH-1:0]     m_idx,
  output logic [PWR_WIDTH-1:0]     m_pwr
`ifdef DOA_SPECTRUM_OUT_EN
  ,
  output logic                     spec_valid,
  output logic [IDX_WIDTH-1:0]     spec_idx,
  output logic [PWR_WIDTH-1:0]     spec_pwr
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(N_ANGLES-1);

  state_t                   state_q, state_d;
  logic [8*WORD_LENGTH-1:0] x_iq_q, x_iq_d;
  logic                     en_q, en_d;
  logic [IDX_WIDTH-1:0]     addr_q, addr_d;
  logic                     rd_vld_q, rd_vld_d;
  logic [IDX_WIDTH-1:0]     rd_idx_q, rd_idx_d;
  logic [PWR_WIDTH-1:0]     best_pwr_q, best_pwr_d;
  logic [IDX_WIDTH-1:0]     best_idx_q, best_idx_d;
  logic                     m_valid_q, m_valid_d;
  logic [IDX_WIDTH-1:0]     m_idx_q, m_idx_d;
  logic [PWR_WIDTH-1:0]     m_pwr_q, m_pwr_d;
  logic                     take;

`ifdef DOA_SPECTRUM_OUT_EN
  logic                     spec_valid_q, spec_valid_d;
  logic [IDX_WIDTH-1:0]     spec_idx_q, spec_idx_d;
  logic [PWR_WIDTH-1:0]     spec_pwr_q, spec_pwr_d;
`endif

  // Strict greater-than keeps the lower index on ties.
  assign take = (rd_idx_q == '0) || ($signed(pwr_in) > $signed(best_pwr_q));

  always_comb begin
    state_d    = state_q;
    x_iq_d     = x_iq_q;
    en_d       = en_q;
    addr_d     = addr_q;
    rd_vld_d   = rd_vld_q;
    rd_idx_d   = rd_idx_q;
    best_pwr_d = best_pwr_q;
    best_idx_d = best_idx_q;
    m_valid_d  = m_valid_q;
    m_idx_d    = m_idx_q;
    m_pwr_d    = m_pwr_q;
`ifdef DOA_SPECTRUM_OUT_EN
    spec_valid_d = 1'b0;
    spec_idx_d   = spec_idx_q;
    spec_pwr_d   = spec_pwr_q;
`endif
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          x_iq_d  = s_iq;
          addr_d  = '0;
          en_d    = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (en_q) begin
          if (addr_q == LAST) begin
            en_d   = 1'b0;
            addr_d = '0;
          end else begin
            addr_d = addr_q + IDX_WIDTH'(1);
          end
        end
        // ROM read issued at addr k returns data one cycle later; tag it with k.
        rd_vld_d = en_q;
        rd_idx_d = addr_q;
        if (rd_vld_q) begin
          if (take) begin
            best_pwr_d = pwr_in;
            best_idx_d = rd_idx_q;
          end
`ifdef DOA_SPECTRUM_OUT_EN
          spec_valid_d = 1'b1;
          spec_idx_d   = rd_idx_q;
          spec_pwr_d   = pwr_in;
`endif
          if (rd_idx_q == LAST) begin
            m_valid_d = 1'b1;
            m_idx_d   = best_idx_d;
            m_pwr_d   = best_pwr_d;
            rd_vld_d  = 1'b0;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort drops the scan/result but leaves best and the last reported result untouched.
    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      m_valid_d  = 1'b0;
      en_d       = 1'b0;
      addr_d     = '0;
      rd_vld_d   = 1'b0;
      best_pwr_d = best_pwr_q;
      best_idx_d = best_idx_q;
      m_idx_d    = m_idx_q;
      m_pwr_d    = m_pwr_q;
`ifdef DOA_SPECTRUM_OUT_EN
      spec_valid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_iq_q     <= '0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      best_pwr_q <= '0;
      best_idx_q <= '0;
      m_valid_q  <= 1'b0;
      m_idx_q    <= '0;
      m_pwr_q    <= '0;
`ifdef DOA_SPECTRUM_OUT_EN
      spec_valid_q <= 1'b0;
      spec_idx_q   <= '0;
      spec_pwr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_iq_q     <= x_iq_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
      best_pwr_q <= best_pwr_d;
      best_idx_q <= best_idx_d;
      m_valid_q  <= m_valid_d;
      m_idx_q    <= m_idx_d;
      m_pwr_q    <= m_pwr_d;
`ifdef DOA_SPECTRUM_OUT_EN
      spec_valid_q <= spec_valid_d;
      spec_idx_q   <= spec_idx_d;
      spec_pwr_q   <= spec_pwr_d;
`endif
    end
  end

  assign s_ready    = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign x_iq       = x_iq_q;
  assign steer_en   = en_q;
  assign steer_addr = addr_q;
  assign m_valid    = m_valid_q;
  assign m_idx      = m_idx_q;
  assign m_pwr      = m_pwr_q;
`ifdef DOA_SPECTRUM_OUT_EN
  assign spec_valid = spec_valid_q;
  assign spec_idx   = spec_idx_q;
  assign spec_pwr   = spec_pwr_q;
`endif

endmodule

// File: tb/tb_doa_scan_ctrl.sv
// Directed bench for doa_scan_ctrl with N_ANGLES=8: registered ROM model feeding a power table.
module tb_doa_scan_ctrl;
  localparam int WL  = 16;
  localparam int PW  = 2*(2*WL+3)+1;
  localparam int NA  = 8;
  localparam int IW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [8*WL-1:0] s_iq = '0;
  logic [8*WL-1:0] x_iq;
  logic          steer_en;
  logic [IW-1:0] steer_addr;
  logic [PW-1:0] pwr_in;
  logic          abort = 1'b0;
  logic          busy;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [IW-1:0] m_idx;
  logic [PW-1:0] m_pwr;

  int tbl[NA];
  logic [IW-1:0] rom_idx = '0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (steer_en) rom_idx <= steer_addr;
  assign pwr_in = PW'(tbl[rom_idx]);

`ifdef DOA_SPECTRUM_OUT_EN
  logic          spec_valid;
  logic [IW-1:0] spec_idx;
  logic [PW-1:0] spec_pwr;
  int sp_n = 0;
  int sp_idx[16];
  longint sp_pwr[16];
  always @(negedge clk) if (spec_valid) begin
    if (sp_n < 16) begin
      sp_idx[sp_n] = int'(spec_idx);
      sp_pwr[sp_n] = longint'(spec_pwr[62:0]);
    end
    sp_n++;
  end
`endif

  doa_scan_ctrl #(.WORD_LENGTH(WL), .PWR_WIDTH(PW), .N_ANGLES(NA), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_iq(s_iq), .x_iq(x_iq),
    .steer_en(steer_en), .steer_addr(steer_addr), .pwr_in(pwr_in), .abort(abort), .busy(busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_pwr(m_pwr)
`ifdef DOA_SPECTRUM_OUT_EN
    , .spec_valid(spec_valid), .spec_idx(spec_idx), .spec_pwr(spec_pwr)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " s_ready"}, 128'(s_ready), 128'(1));
    chk({tag, " busy"}, 128'(busy), 128'(0));
    chk({tag, " m_valid"}, 128'(m_valid), 128'(0));
    chk({tag, " steer_en"}, 128'(steer_en), 128'(0));
    chk({tag, " steer_addr"}, 128'(steer_addr), 128'(0));
    chk({tag, " x_iq"}, 128'(x_iq), 128'(0));
    chk({tag, " m_idx"}, 128'(m_idx), 128'(0));
    chk({tag, " m_pwr"}, 128'(m_pwr), 128'(0));
  endtask

  // Accept one snapshot at the next edge; returns #1 after that edge.
  task automatic accept(input logic [8*WL-1:0] iq);
    s_valid = 1'b1;
    s_iq = iq;
    step();
    s_valid = 1'b0;
  endtask

  // From just after the accept edge, run to the result edge (E9) checking m_valid stays low.
  task automatic run_scan(input string tag);
    for (int k = 1; k <= NA; k++) begin
      step();
      chk({tag, " m_valid low"}, 128'(m_valid), 128'(0));
    end
    step();
    chk({tag, " m_valid"}, 128'(m_valid), 128'(1));
  endtask

  task automatic handshake(input string tag);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk({tag, " hs m_valid"}, 128'(m_valid), 128'(0));
    chk({tag, " hs s_ready"}, 128'(s_ready), 128'(1));
  endtask

  initial begin
    logic [8*WL-1:0] iq_a;
    logic [8*WL-1:0] iq_b;
    iq_a = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    iq_b = {16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hB001, 16'hB002, 16'hB003, 16'hB004};
    tbl = '{5, 9, 3, 9, 1, 0, 2, 4};
    #12 rst = 1'b0;
    step();
    chk_reset("t0 reset");

    // 1: addr sweep and argmax with a tie
    accept(iq_a);
    chk("t1 x_iq", 128'(x_iq), 128'(iq_a));
    chk("t1 steer_en", 128'(steer_en), 128'(1));
    chk("t1 addr0", 128'(steer_addr), 128'(0));
    chk("t1 busy", 128'(busy), 128'(1));
    chk("t1 s_ready", 128'(s_ready), 128'(0));
    for (int k = 1; k < NA; k++) begin
      step();
      chk("t1 addr", 128'(steer_addr), 128'(k));
      chk("t1 en", 128'(steer_en), 128'(1));
      chk("t1 m_valid low", 128'(m_valid), 128'(0));
    end
    step();
    chk("t1 en drop", 128'(steer_en), 128'(0));
    chk("t1 addr back", 128'(steer_addr), 128'(0));
    chk("t1 m_valid low E8", 128'(m_valid), 128'(0));
    step();
    chk("t1 m_valid", 128'(m_valid), 128'(1));
    chk("t1 m_idx", 128'(m_idx), 128'(1));
    chk("t1 m_pwr", 128'(m_pwr), 128'(9));
    handshake("t1");
`ifdef DOA_SPECTRUM_OUT_EN
    // 6: spectrum stream
    chk("t6 spec count", 128'(sp_n), 128'(NA));
    for (int k = 0; k < NA; k++) begin
      chk("t6 spec_idx", 128'(sp_idx[k]), 128'(k));
      chk("t6 spec_pwr", 128'(sp_pwr[k]), 128'(tbl[k]));
    end
    chk("t6 spec_valid idle", 128'(spec_valid), 128'(0));
`endif

    // 2: backpressure on the result
    tbl = '{0, 0, 0, 0, 0, 0, 0, 7};
    accept(iq_b);
    run_scan("t2");
    for (int c = 0; c < 20; c++) begin
      step();
      chk("t2 hold m_valid", 128'(m_valid), 128'(1));
      chk("t2 hold m_idx", 128'(m_idx), 128'(7));
      chk("t2 hold m_pwr", 128'(m_pwr), 128'(7));
      chk("t2 hold s_ready", 128'(s_ready), 128'(0));
    end
    handshake("t2");

    // 3: abort four edges after accept
    tbl = '{2, 1, 6, 6, 0, 8, 8, 3};
    accept(iq_a);
    step(); step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t3 s_ready", 128'(s_ready), 128'(1));
    chk("t3 busy", 128'(busy), 128'(0));
    chk("t3 steer_en", 128'(steer_en), 128'(0));
    chk("t3 steer_addr", 128'(steer_addr), 128'(0));
    chk("t3 m_idx held", 128'(m_idx), 128'(7));
    chk("t3 m_pwr held", 128'(m_pwr), 128'(7));
    for (int c = 0; c < 12; c++) begin
      step();
      chk("t3 no m_valid", 128'(m_valid), 128'(0));
    end
    accept(iq_b);
    run_scan("t3b");
    chk("t3b m_idx", 128'(m_idx), 128'(5));
    chk("t3b m_pwr", 128'(m_pwr), 128'(8));
    handshake("t3b");

    // 4: async reset mid-scan
    accept(iq_a);
    for (int k = 1; k <= 5; k++) step();
    chk("t4 addr5", 128'(steer_addr), 128'(5));
    rst = 1'b1;
    #1;
    chk_reset("t4 async");
    #2 rst = 1'b0;
    tbl = '{1, 2, 3, 4, 5, 6, 7, 8};
    step();
    chk("t4 no m_valid", 128'(m_valid), 128'(0));
    accept(iq_b);
    run_scan("t4b");
    chk("t4b m_idx", 128'(m_idx), 128'(7));
    chk("t4b m_pwr", 128'(m_pwr), 128'(8));
    handshake("t4b");

    // 5: s_valid held, m_ready held
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_iq = iq_a;
    step();
    s_iq = iq_b;
    chk("t5 x_iq a", 128'(x_iq), 128'(iq_a));
    for (int k = 1; k <= NA; k++) begin
      step();
      chk("t5 x_iq held", 128'(x_iq), 128'(iq_a));
      chk("t5 s_ready low", 128'(s_ready), 128'(0));
    end
    step();
    chk("t5 m_valid", 128'(m_valid), 128'(1));
    chk("t5 no accept on result", 128'(x_iq), 128'(iq_a));
    step();
    chk("t5 hs m_valid", 128'(m_valid), 128'(0));
    chk("t5 hs s_ready", 128'(s_ready), 128'(1));
    chk("t5 x_iq still a", 128'(x_iq), 128'(iq_a));
    step();
    chk("t5 x_iq b", 128'(x_iq), 128'(iq_b));
    chk("t5 busy", 128'(busy), 128'(1));
    s_valid = 1'b0;
    m_ready = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5 abort idle", 128'(s_ready), 128'(1));
    chk("t5 x_iq kept", 128'(x_iq), 128'(iq_b));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
